// File: rtl/memory_unit_pkg.sv
// Shared definitions for the memory subsystem: loader FSM states,
// default geometry and the controller opcode set.
package memory_unit_pkg;

    localparam int MU_ADDR_WIDTH = 4;
    localparam int MU_DEPTH      = 16;
    localparam int MU_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } mu_state_e;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'he;
    localparam logic [3:0] OP_HLT = 4'hf;

endpackage

// File: rtl/ram_sp_async.sv
// Single-port RAM: synchronous write, asynchronous read.
// Contents have no reset so a program survives a system reset.
module ram_sp_async #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/memory_unit.sv
// MAR, program RAM and checksummed byte-stream loader on the shared bus.
// The CPU is held in reset until a verified program is resident.
module memory_unit
    import memory_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = MU_ADDR_WIDTH,
    parameter int DEPTH      = MU_DEPTH,
    parameter int DATA_WIDTH = MU_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    inout  wire  [DATA_WIDTH-1:0] o_bus,
    input  logic                  i_reg_mem_write_n,
    input  logic                  i_mem_read_n,
    input  logic                  i_mem_write_n,
    input  logic                  i_load_start,
    input  logic                  i_load_valid,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    output logic                  o_load_ready,
    output logic                  o_load_busy,
    output logic                  o_load_done,
    output logic                  o_load_error,
    output logic                  o_cpu_reset
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    mu_state_e r_state;
    mu_state_e w_next;

    logic [ADDR_WIDTH-1:0] r_mar;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_done;
    logic                  r_error;
    logic                  r_cpu_reset;

    logic                  w_accept;
    logic                  w_ld_we;
    logic                  w_chk_ok;
    logic                  w_chk_bad;
    logic                  w_run;
    logic                  w_bus_we;
    logic                  w_bus_rd;
    logic                  w_mar_we;
    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_waddr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    // A start pulse wins over a coincident byte, so that byte is dropped.
    assign w_accept  = i_load_valid & o_load_ready & ~i_load_start;
    assign w_ld_we   = w_accept & (r_state == ST_LOAD);
    assign w_chk_ok  = w_accept & (r_state == ST_CHECK) & (i_load_data == r_sum);
    assign w_chk_bad = w_accept & (r_state == ST_CHECK) & (i_load_data != r_sum);

    assign w_run    = (r_state == ST_RUN);
    assign w_bus_we = w_run & ~i_mem_write_n;
    assign w_bus_rd = w_run & ~i_mem_read_n & i_mem_write_n;
    assign w_mar_we = w_run & ~i_reg_mem_write_n;

    always_comb begin
        w_next       = r_state;
        o_load_ready = 1'b0;
        o_load_busy  = 1'b0;
        if (i_load_start) begin
            w_next = ST_LOAD;
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    if (w_accept && r_cnt == LAST) w_next = ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_chk_ok)  w_next = ST_RUN;
                    if (w_chk_bad) w_next = ST_ERROR;
                end
                default: w_next = r_state;
            endcase
        end
        if (r_state == ST_LOAD || r_state == ST_CHECK) begin
            o_load_ready = 1'b1;
            o_load_busy  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_mar       <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_reset <= 1'b1;
        end else begin
            r_state <= w_next;
            r_done  <= w_chk_ok;
            if (w_chk_ok) begin
                r_error <= 1'b0;
            end else if (w_chk_bad) begin
                r_error <= 1'b1;
            end
            // Release lags RUN entry by one cycle.
            r_cpu_reset <= i_load_start | (r_state != ST_RUN);
            if (i_load_start) begin
                r_cnt <= '0;
                r_sum <= '0;
            end else if (w_ld_we) begin
                r_cnt <= r_cnt + 1'b1;
                r_sum <= r_sum + i_load_data;
            end
            if (w_mar_we) begin
                r_mar <= o_bus[ADDR_WIDTH-1:0];
            end
        end
    end

    assign w_ram_we    = w_ld_we | w_bus_we;
    assign w_ram_waddr = w_ld_we ? r_cnt : r_mar;
    assign w_ram_wdata = w_ld_we ? i_load_data : o_bus;

    ram_sp_async #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (r_mar),
        .o_rdata (w_ram_rdata)
    );

    assign o_bus = w_bus_rd ? w_ram_rdata : {DATA_WIDTH{1'bz}};

    assign o_load_done  = r_done;
    assign o_load_error = r_error;
    assign o_cpu_reset  = r_cpu_reset;

endmodule

// File: tb/tb_memory_unit.sv
// Scoreboard bench for memory_unit: reads queue expected bus bytes,
// a negedge monitor pops and compares them.
module tb_memory_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       rmw_n, rd_n, wr_n;
    logic       start, valid;
    logic [7:0] ldata;
    logic       ready, busy, done, error, cpu_rst;
    logic       tb_drv;
    logic [7:0] tb_val;
    wire  [7:0] bus;

    typedef struct {
        string      name;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;

    assign bus = tb_drv ? tb_val : 8'hzz;

    always #5 clk = ~clk;

    memory_unit dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .o_bus             (bus),
        .i_reg_mem_write_n (rmw_n),
        .i_mem_read_n      (rd_n),
        .i_mem_write_n     (wr_n),
        .i_load_start      (start),
        .i_load_valid      (valid),
        .i_load_data       (ldata),
        .o_load_ready      (ready),
        .o_load_busy       (busy),
        .o_load_done       (done),
        .o_load_error      (error),
        .o_cpu_reset       (cpu_rst)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (!rst && !rd_n && wr_n && !tb_drv) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_read actual=%0h required=none", bus);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk(e.name, {24'h0, bus}, {24'h0, e.data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        valid = 1'b1;
        ldata = b;
        step();
        valid = 1'b0;
    endtask

    task automatic load_prog(input logic [7:0] base, input logic [7:0] cks);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < 16; i++) send(base + 8'(i));
        send(cks);
    endtask

    task automatic mar_load(input logic [7:0] a);
        tb_drv = 1'b1;
        tb_val = a;
        rmw_n  = 1'b0;
        step();
        rmw_n  = 1'b1;
        tb_drv = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp,
                      input string name);
        mar_load(a);
        rd_n = 1'b0;
        exp_q.push_back('{name, exp});
        step();
        rd_n = 1'b1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        mar_load(a);
        tb_drv = 1'b1;
        tb_val = d;
        wr_n   = 1'b0;
        step();
        wr_n   = 1'b1;
        tb_drv = 1'b0;
    endtask

    // Bus is checked for "not driven by the DUT" by driving 0x00 from
    // the bench while the addressed RAM byte is non-zero.
    task automatic bus_quiet(input string name);
        tb_drv = 1'b1;
        tb_val = 8'h00;
        rd_n   = 1'b0;
        #2;
        chk(name, {24'h0, bus}, 0);
        rd_n   = 1'b1;
        tb_drv = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rmw_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        start = 1'b0; valid = 1'b0; ldata = 8'h00;
        tb_drv = 1'b0; tb_val = 8'h00;
        step();
        step();
        chk("rst_cpu_reset", cpu_rst, 1);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        rst = 1'b0;
        step();

        load_prog(8'h00, 8'h78);
        chk("good_done", done, 1);
        chk("good_cpu_rst_hold", cpu_rst, 1);
        chk("good_error", error, 0);
        step();
        chk("good_done_pulse", done, 0);
        chk("good_cpu_rst_fall", cpu_rst, 0);

        for (int i = 0; i < 16; i++) begin
            rd(8'hF0 | 8'(i), 8'(i), $sformatf("mem_%0d", i));
        end

        mar_load(8'hF5);
        tb_drv = 1'b1;
        tb_val = 8'h00;
        rd_n = 1'b0;
        wr_n = 1'b0;
        #2;
        chk("rd_wr_not_driven", {24'h0, bus}, 0);
        step();
        rd_n = 1'b1;
        wr_n = 1'b1;
        #1;
        chk("bus_z_after", {24'h0, bus}, 0);
        tb_drv = 1'b0;
        rd(8'h05, 8'h00, "rd_wr_wrote");

        wr(8'h03, 8'hA7);
        rd(8'h03, 8'hA7, "run_write");
        wr(8'h05, 8'h05);

        load_prog(8'h00, 8'h79);
        chk("bad_done", done, 0);
        chk("bad_error", error, 1);
        chk("bad_cpu_rst", cpu_rst, 1);
        step();
        step();
        chk("bad_error_sticky", error, 1);
        chk("bad_cpu_rst_hold", cpu_rst, 1);
        bus_quiet("err_read_ignored");

        load_prog(8'h00, 8'h78);
        chk("reload_done", done, 1);
        chk("reload_error_clr", error, 0);
        step();
        chk("reload_cpu_rst", cpu_rst, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) send(8'hC0 + 8'(i));
        rst = 1'b1;
        step();
        chk("midrst_ready", ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cpu_rst", cpu_rst, 1);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("keep_%0d", i), {24'h0, dut.u_ram.r_mem[i]},
                {24'h0, 8'hC0 + 8'(i)});
        end
        chk("keep_7_old", {24'h0, dut.u_ram.r_mem[7]}, 32'h07);
        bus_quiet("idle_read_ignored");
        step();
        chk("idle_cpu_rst", cpu_rst, 1);

        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(i));
        chk("check_ready", ready, 1);
        start = 1'b1;
        valid = 1'b1;
        ldata = 8'h55;
        step();
        start = 1'b0;
        valid = 1'b0;
        send(8'h20);
        chk("restart_mem0", {24'h0, dut.u_ram.r_mem[0]}, 32'h20);
        for (int i = 1; i < 16; i++) send(8'h20 + 8'(i));
        send(8'h78);
        chk("restart_done", done, 1);
        step();
        chk("restart_cpu_rst", cpu_rst, 0);
        rd(8'h00, 8'h20, "restart_rd0");
        rd(8'h0F, 8'h2F, "restart_rd15");

        step();
        chk("done_pulses", done_cnt, 3);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_unit.md
Name: memory_unit

Overview:
Memory subsystem sitting directly downstream of the CPU controller on the shared 8-bit bus. It contains the memory address register (MAR), a DEPTH x 8 RAM, and a byte-stream program loader. The controller drives MAR load, memory read and memory write strobes; the memory returns instruction and data bytes onto the bus. The loader fills the RAM from an external byte source, such as a UART receiver, and holds the CPU in reset until a checksum-verified program is in place.

Parameters:
ADDR_WIDTH, 4, MAR width and RAM address width
DEPTH, 16, number of RAM bytes; equals 2**ADDR_WIDTH
DATA_WIDTH, 8, bus and RAM word width

Ports:
i_clk  input  1  system clock, all logic on posedge
i_reset  input  1  synchronous, active-high reset
o_bus  inout  DATA_WIDTH  shared CPU bus; driven only during a memory read, otherwise Z
i_reg_mem_write_n  input  1  active-low; latch o_bus[ADDR_WIDTH-1:0] into the MAR
i_mem_read_n  input  1  active-low; drive mem[MAR] onto o_bus
i_mem_write_n  input  1  active-low; write o_bus into mem[MAR]
i_load_start  input  1  one-cycle pulse; begin program load
i_load_valid  input  1  loader byte valid
i_load_data  input  DATA_WIDTH  loader byte
o_load_ready  output  1  loader can accept a byte
o_load_busy  output  1  high in LOAD or CHECK
o_load_done  output  1  one-cycle pulse on successful checksum
o_load_error  output  1  sticky checksum-mismatch flag
o_cpu_reset  output  1  registered, active-high reset to controller, PC and registers

Behaviour:
- Clocking and reset: one clock, i_clk. i_reset is synchronous and active-high.
- Reset values:
  - state = IDLE, MAR = 0, load counter = 0, running sum = 0.
  - o_cpu_reset = 1; o_load_ready, o_load_busy, o_load_done and o_load_error = 0.
  - o_bus = Z.
  - RAM contents are not cleared by reset.
- IDLE:
  - CPU is held in reset and bus strobes are ignored.
  - i_load_start moves to LOAD.
- LOAD:
  - On entry: counter = 0, sum = 0.
  - o_load_ready = 1 and o_load_busy = 1.
  - Each cycle with i_load_valid & o_load_ready: mem[counter] <= i_load_data, sum <= sum + i_load_data (mod 256), counter++.
  - After the DEPTH-th accepted byte, move to CHECK.
  - Bus strobes are ignored and o_bus = Z.
- CHECK:
  - o_load_ready = 1. The next accepted byte is the checksum; it is not stored.
  - If it equals sum: go to RUN, pulse o_load_done for that cycle, clear o_load_error. o_cpu_reset goes 0 one cycle after entering RUN.
  - If it does not match: go to ERROR and set o_load_error = 1.
- RUN:
  - Normal CPU operation.
  - MAR: on a posedge with i_reg_mem_write_n = 0, MAR <= o_bus[ADDR_WIDTH-1:0]. The upper bus bits are ignored.
  - Read: asynchronous. While i_mem_read_n = 0, o_bus = mem[MAR]; this value is valid in the same cycle, so the consumer latches it at the next edge.
  - Write: on a posedge with i_mem_write_n = 0, mem[MAR] <= o_bus.
  - Simultaneous MAR load and read: the read uses the old MAR, and the new MAR takes effect next cycle.
  - Simultaneous MAR load and write: the write uses the old MAR.
  - Read and write strobes both low: the write wins and o_bus is not driven, which prevents self-contention.
- ERROR:
  - o_cpu_reset stays 1 and o_load_error stays 1.
  - Only i_load_start (back to LOAD) or i_reset exits this state.
- i_load_start behaviour:
  - Accepted in IDLE, RUN, ERROR, LOAD and CHECK; it always restarts LOAD with counter and sum cleared.
  - o_cpu_reset = 1 from the cycle after the pulse.
  - A start pulse that coincides with a valid byte drops that byte.
- i_reset in the middle of a load: go to IDLE. Bytes already written stay in RAM, and the CPU stays in reset.
- Counter wraps naturally at DEPTH; no byte is ever written past DEPTH-1.

Decomposition:
- Shared defines file:
  - memory_unit state encodings: IDLE, LOAD, CHECK, RUN, ERROR (3 bits).
  - Defaults for ADDR_WIDTH, DEPTH and DATA_WIDTH.
  - These defines are alongside the existing opcode defines.
- One sub-module, ram_sp_async: DEPTH x DATA_WIDTH array with one synchronous write port and one asynchronous read port. Its write port is muxed between the loader and the bus.
- The MAR, the loader FSM and the bus tristate stay in memory_unit.

Test Plan:
- Successful load:
  - Stimulus: reset, pulse i_load_start, stream bytes 0x00..0x0F, then checksum 0x78.
  - Required: o_load_done pulses once, o_cpu_reset falls the next cycle, mem[i] = i.
- Bad checksum:
  - Stimulus: same 16 bytes followed by 0x79.
  - Required: o_load_error = 1 and o_cpu_reset stays 1. A second load with 0x78 clears the error and releases reset.
- RUN read:
  - Stimulus: i_reg_mem_write_n = 0 with bus 0xF5, next cycle i_mem_read_n = 0.
  - Required: o_bus = mem[5]. With both strobes low o_bus = Z; it is Z again after the strobe ends.
- RUN write:
  - Stimulus: MAR = 0x3, bus 0xA7 driven with i_mem_write_n = 0.
  - Required: a later read at address 3 returns 0xA7. If read and write are asserted together, o_bus is not driven.
- Reset in the middle of a load:
  - Stimulus: assert i_reset after 7 accepted bytes.
  - Required: state IDLE, o_cpu_reset = 1, o_load_ready = 0, bytes 0..6 retained. Strobes are ignored until a new load completes.
- Restart during CHECK:
  - Stimulus: i_load_start pulsed in CHECK.
  - Required: counter and sum restart at 0, and the next byte is written to mem[0].
